gate_rx_deframer: RTL and testbench
===================================

Name: gate_rx_deframer

Overview:
Receive-side deframer for the inter-FPGA gate link. It takes one parallel word per core clock from the LVDS deserializer and hunts for the stable sync pattern, which signals link training complete. After that it detects frame headers and reassembles GATE_FOLDS payload words into one gate vector of flits, valids and credits. Completed gates are buffered in a 2-entry show-ahead queue that the emulation state machine drains with a pull strobe. It is the receiving counterpart of the transmit framer inside the LVDS bridge.

Parameters:
FLIT_WIDTH, 8, bits per flit
GATE_WIDTH, 8, NoC channels per gate
GATE_FOLDS, 3, payload words per frame; GATE_FOLDS*WORD_WIDTH must be at least GATE_WIDTH*(FLIT_WIDTH+2)
WORD_WIDTH, 28, deserialized word width (LVDS_CHANNELS*LVDS_SERIALIZATION)
SYNC_PATTERN, 1, training word value
START_PATTERN, 28'h5A5A5A5, frame header word value
STABLE_CYCLES, 1000000, consecutive sync words required for lock

Ports:
i_clk  in  1  core clock
i_rst  in  1  reset, asynchronous, active-high
i_word  in  WORD_WIDTH  deserialized word, one per cycle
i_sync_generate  in  1  level; while high, deframer is held in hunt and flushed
i_rx_pull  in  1  pop head gate, single-cycle strobe
o_rx_available  out  1  queue non-empty
o_sync_complete  out  1  link locked
o_dt  out  [GATE_WIDTH-1:0][FLIT_WIDTH-1:0]  head gate flits, unpacked array
o_vl  out  GATE_WIDTH  head gate valids
o_cr  out  GATE_WIDTH  head gate credits
o_overflow  out  1  sticky; a frame was dropped
o_frame_err  out  1  sticky; unexpected word seen in idle

Behaviour:
- Reset: state HUNT, counters 0, queue empty, all outputs 0.
- Payload mapping: P is GATE_FOLDS*WORD_WIDTH bits.
  - Fold k (k-th word after the header) fills P[k*WORD_WIDTH +: WORD_WIDTH].
  - Flit i = P[i*FLIT_WIDTH +: FLIT_WIDTH].
  - o_vl = P[GW*FW +: GW], o_cr = P[GW*FW+GW +: GW].
  - Pad bits are ignored.
- HUNT:
  - Counter increments when i_word == SYNC_PATTERN and clears to 0 on any other word.
  - The counter is $clog2(STABLE_CYCLES+1) bits and saturates.
  - When the STABLE_CYCLES-th consecutive match is sampled, go to IDLE. o_sync_complete rises on the next cycle and stays high until i_sync_generate or reset.
- IDLE:
  - START_PATTERN: go to DATA with fold counter 0.
  - 0 or SYNC_PATTERN: stay in IDLE.
  - Any other word: set o_frame_err and stay in IDLE.
- DATA:
  - Each cycle, capture i_word into fold slot and increment the fold counter. No header checks are made inside a frame.
  - On the last fold, push P into the queue and return to IDLE. A header is accepted on the very next cycle, so back-to-back frames are 1+GATE_FOLDS cycles apart.
- Latency: last fold sampled at cycle t gives o_rx_available=1 and a valid head at t+1.
- Queue:
  - 2 entries, show-ahead. o_dt/o_vl/o_cr are the head entry and hold their last value when the queue is empty.
  - Pull when empty is ignored.
  - Push when full with no pull: the new frame is dropped and o_overflow is set.
  - Push and pull together when full: both take effect, no overflow.
  - Push and pull together when holding 1 entry: count stays 1, and the head becomes the new frame.
- i_sync_generate high in any state, including mid-frame, takes effect the next cycle:
  - state to HUNT;
  - flush the queue (o_rx_available 0);
  - clear o_sync_complete, o_overflow and o_frame_err;
  - clear the fold counter and sync counter.
  - The sync counter does not start counting until i_sync_generate is low.
- Asynchronous reset mid-frame discards the partial frame.

Decomposition:
- Package gate_link_pkg:
  - state enum {HUNT, IDLE, DATA};
  - localparams PAYLOAD_W, FLITS_W, VL_OFS, CR_OFS;
  - widths for the fold counter and sync counter.
- Sub-module gate_frame_fifo: 2-entry show-ahead FIFO of PAYLOAD_W bits with push/pull/full/empty. The deframer FSM and the field slicing stay in the top module.

Test Plan:
All tests use STABLE_CYCLES=8 and defaults otherwise.
1. Sync lock: drive 7×1, then 0, then 8×1 → o_sync_complete stays 0 through the first run and rises one cycle after the 8th consecutive 1 of the second run.
2. Frame decode: after lock, drive 5A5A5A5, W0, W1, then W2=28'h0C3A5F1 → next cycle o_rx_available=1, o_dt[7]=8'hF1, o_vl=8'hA5, o_cr=8'hC3, and flits 0..6 match W0/W1 slices.
3. Overflow: three back-to-back frames A, B, C with no pull → o_overflow=1. Two pulls yield A then B; o_rx_available is 0 after the second pull.
4. Full plus simultaneous: with the queue full (A, B), C's last fold coincides with a pull → o_overflow stays 0, and the subsequent heads are B then C.
5. Frame error: in IDLE drive 28'h1234567 → o_frame_err=1. A following frame is still decoded correctly.
6. Resync mid-frame: assert i_sync_generate after fold 1 → next cycle o_sync_complete=0, o_rx_available=0, and both sticky flags are cleared. Relock needs 8 sync words after deassertion.

Source files
------------

// File: rtl/gate_link_pkg.sv
// Shared types and width helpers for the gate link deframer.
// Pure declarations; no logic, no latency, no flow control.
// Width helpers let instances with non-default parameters derive their own field offsets.
package gate_link_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic int payload_w(input int folds, input int word_w);
        return folds * word_w;
    endfunction

    function automatic int flits_w(input int gate_w, input int flit_w);
        return gate_w * flit_w;
    endfunction

    function automatic int vl_ofs(input int gate_w, input int flit_w);
        return gate_w * flit_w;
    endfunction

    function automatic int cr_ofs(input int gate_w, input int flit_w);
        return gate_w * flit_w + gate_w;
    endfunction

    function automatic int fold_cnt_w(input int folds);
        return (folds > 1) ? $clog2(folds) : 1;
    endfunction

    function automatic int sync_cnt_w(input int stable);
        return $clog2(stable + 1);
    endfunction

    // Default link configuration.
    localparam int DEF_FLIT_WIDTH    = 8;
    localparam int DEF_GATE_WIDTH    = 8;
    localparam int DEF_GATE_FOLDS    = 3;
    localparam int DEF_WORD_WIDTH    = 28;
    localparam int DEF_STABLE_CYCLES = 1000000;

    localparam int PAYLOAD_W  = payload_w(DEF_GATE_FOLDS, DEF_WORD_WIDTH);
    localparam int FLITS_W    = flits_w(DEF_GATE_WIDTH, DEF_FLIT_WIDTH);
    localparam int VL_OFS     = vl_ofs(DEF_GATE_WIDTH, DEF_FLIT_WIDTH);
    localparam int CR_OFS     = cr_ofs(DEF_GATE_WIDTH, DEF_FLIT_WIDTH);
    localparam int FOLD_CNT_W = fold_cnt_w(DEF_GATE_FOLDS);
    localparam int SYNC_CNT_W = sync_cnt_w(DEF_STABLE_CYCLES);

endpackage

// File: rtl/gate_frame_fifo.sv
// Two-entry show-ahead queue of assembled gate payloads.
// Latency: a push is visible at the head on the cycle after it is accepted.
// Backpressure: none; a push while full without a pull is dropped (caller flags it).
module gate_frame_fifo
    import gate_link_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pull,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             pull_ok;

    assign pull_ok = i_pull && (cnt_q != 2'd0);

    // The head register is left untouched on flush/drain so outputs hold their last value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else if (i_flush) begin
            cnt_q <= 2'd0;
        end else begin
            case ({i_push, pull_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= i_push_dat;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_q <= i_push_dat;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= i_push_dat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head_dat = head_q;
    assign o_full     = (cnt_q == 2'd2);
    assign o_empty    = (cnt_q == 2'd0);

endmodule

// File: rtl/gate_rx_deframer.sv
// Gate link receive deframer: sync hunt, header detect, fold reassembly into a 2-deep queue.
// Latency: last fold sampled at cycle t gives a valid head and o_rx_available at t+1.
// Backpressure: none upstream; frames arriving to a full queue are dropped and o_overflow set.
module gate_rx_deframer
    import gate_link_pkg::*;
#(
    parameter int                    FLIT_WIDTH    = DEF_FLIT_WIDTH,
    parameter int                    GATE_WIDTH    = DEF_GATE_WIDTH,
    parameter int                    GATE_FOLDS    = DEF_GATE_FOLDS,
    parameter int                    WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN  = WORD_WIDTH'(1),
    parameter logic [WORD_WIDTH-1:0] START_PATTERN = WORD_WIDTH'(28'h5A5A5A5),
    parameter int                    STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [WORD_WIDTH-1:0]                i_word,
    input  logic                                 i_sync_generate,
    input  logic                                 i_rx_pull,
    output logic                                 o_rx_available,
    output logic                                 o_sync_complete,
    output logic [GATE_WIDTH-1:0][FLIT_WIDTH-1:0] o_dt,
    output logic [GATE_WIDTH-1:0]                o_vl,
    output logic [GATE_WIDTH-1:0]                o_cr,
    output logic                                 o_overflow,
    output logic                                 o_frame_err
);

    localparam int PW     = payload_w(GATE_FOLDS, WORD_WIDTH);
    localparam int FW_ALL = flits_w(GATE_WIDTH, FLIT_WIDTH);
    localparam int VL_O   = vl_ofs(GATE_WIDTH, FLIT_WIDTH);
    localparam int CR_O   = cr_ofs(GATE_WIDTH, FLIT_WIDTH);
    localparam int USED_W = CR_O + GATE_WIDTH;
    localparam int FOLD_W = fold_cnt_w(GATE_FOLDS);
    localparam int SYNC_W = sync_cnt_w(STABLE_CYCLES);

    localparam logic [FOLD_W-1:0] LAST_FOLD = FOLD_W'(GATE_FOLDS - 1);
    localparam logic [SYNC_W-1:0] LOCK_AT   = SYNC_W'(STABLE_CYCLES - 1);
    localparam logic [SYNC_W-1:0] SYNC_MAX  = SYNC_W'(STABLE_CYCLES);

    if (PW < USED_W) begin : g_width_check
        $error("GATE_FOLDS*WORD_WIDTH too small for GATE_WIDTH*(FLIT_WIDTH+2)");
    end

    state_t              state_q, state_d;
    logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [FOLD_W-1:0]   fold_cnt_q, fold_cnt_d;
    logic [WORD_WIDTH-1:0] fold_q [GATE_FOLDS-1];
    logic                capture;
    logic                push;
    logic                lock;
    logic                frame_err_set;
    logic [PW-1:0]       payload;
    logic [PW-1:0]       head_dat;
    logic                fifo_full;
    logic                fifo_empty;
    logic                sync_complete_q;
    logic                overflow_q;
    logic                frame_err_q;

    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        fold_cnt_d    = fold_cnt_q;
        capture       = 1'b0;
        push          = 1'b0;
        lock          = 1'b0;
        frame_err_set = 1'b0;
        if (i_sync_generate) begin
            state_d    = HUNT;
            sync_cnt_d = '0;
            fold_cnt_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (i_word == SYNC_PATTERN) begin
                        if (sync_cnt_q == LOCK_AT) begin
                            state_d    = IDLE;
                            sync_cnt_d = '0;
                            lock       = 1'b1;
                        end else if (sync_cnt_q != SYNC_MAX) begin
                            sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                        end
                    end else begin
                        sync_cnt_d = '0;
                    end
                end
                IDLE: begin
                    if (i_word == START_PATTERN) begin
                        state_d    = DATA;
                        fold_cnt_d = '0;
                    end else if (i_word != '0 && i_word != SYNC_PATTERN) begin
                        frame_err_set = 1'b1;
                    end
                end
                DATA: begin
                    capture = 1'b1;
                    if (fold_cnt_q == LAST_FOLD) begin
                        push       = 1'b1;
                        fold_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        fold_cnt_d = fold_cnt_q + FOLD_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // The final fold bypasses the slot registers so the frame is queued on the cycle it completes.
    always_comb begin
        payload = '0;
        for (int k = 0; k < GATE_FOLDS - 1; k++) begin
            payload[k*WORD_WIDTH +: WORD_WIDTH] = fold_q[k];
        end
        payload[(GATE_FOLDS-1)*WORD_WIDTH +: WORD_WIDTH] = i_word;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= HUNT;
            sync_cnt_q <= '0;
            fold_cnt_q <= '0;
            for (int k = 0; k < GATE_FOLDS - 1; k++) begin
                fold_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            fold_cnt_q <= fold_cnt_d;
            for (int k = 0; k < GATE_FOLDS - 1; k++) begin
                if (capture && fold_cnt_q == FOLD_W'(k)) begin
                    fold_q[k] <= i_word;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_complete_q <= 1'b0;
            overflow_q      <= 1'b0;
            frame_err_q     <= 1'b0;
        end else if (i_sync_generate) begin
            sync_complete_q <= 1'b0;
            overflow_q      <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            if (lock) begin
                sync_complete_q <= 1'b1;
            end
            if (push && fifo_full && !i_rx_pull) begin
                overflow_q <= 1'b1;
            end
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    gate_frame_fifo #(
        .WIDTH (PW)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_sync_generate),
        .i_push     (push),
        .i_push_dat (payload),
        .i_pull     (i_rx_pull),
        .o_head_dat (head_dat),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    if (PW > USED_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^head_dat[PW-1:USED_W];
    end

    assign o_dt            = head_dat[FW_ALL-1:0];
    assign o_vl            = head_dat[VL_O +: GATE_WIDTH];
    assign o_cr            = head_dat[CR_O +: GATE_WIDTH];
    assign o_rx_available  = !fifo_empty;
    assign o_sync_complete = sync_complete_q;
    assign o_overflow      = overflow_q;
    assign o_frame_err     = frame_err_q;

endmodule

// File: tb/tb_gate_rx_deframer.sv
// Bench for gate_rx_deframer: vector table, directed corner sequences, then random traffic
// checked every cycle against a queue-based reference model of the link rules.
module tb_gate_rx_deframer;

    localparam int STABLE = 8;
    localparam int FOLDS  = 3;
    localparam logic [27:0] START = 28'h5A5A5A5;

    logic                 i_clk;
    logic                 i_rst;
    logic [27:0]          i_word;
    logic                 i_sync_generate;
    logic                 i_rx_pull;
    logic                 o_rx_available;
    logic                 o_sync_complete;
    logic [7:0][7:0]      o_dt;
    logic [7:0]           o_vl;
    logic [7:0]           o_cr;
    logic                 o_overflow;
    logic                 o_frame_err;

    gate_rx_deframer #(
        .STABLE_CYCLES (STABLE)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_word          (i_word),
        .i_sync_generate (i_sync_generate),
        .i_rx_pull       (i_rx_pull),
        .o_rx_available  (o_rx_available),
        .o_sync_complete (o_sync_complete),
        .o_dt            (o_dt),
        .o_vl            (o_vl),
        .o_cr            (o_cr),
        .o_overflow      (o_overflow),
        .o_frame_err     (o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: link lock flag, frame-in-progress flag, payload buffer and a 2-deep queue.
    bit          m_locked;
    bit          m_in_frame;
    int          m_run;
    int          m_k;
    logic [83:0] m_pay;
    logic [83:0] m_q[$];
    logic [83:0] m_head;
    bit          m_ovf;
    bit          m_ferr;
    bit          m_sync;

    typedef struct {
        logic [27:0] word;
        logic        sg;
        logic        pull;
        logic        e_sync;
        logic        e_avail;
        logic        e_ovf;
        logic        e_ferr;
    } vec_t;

    vec_t tbl[32];
    int   n_tbl = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked   = 0;
        m_in_frame = 0;
        m_run      = 0;
        m_k        = 0;
        m_pay      = '0;
        m_q.delete();
        m_head     = '0;
        m_ovf      = 0;
        m_ferr     = 0;
        m_sync     = 0;
    endtask

    task automatic model_update(input logic [27:0] w, input logic sg, input logic pl);
        bit          push;
        bit          pull_ok;
        logic [83:0] np;
        push = 0;
        np   = '0;
        if (sg) begin
            m_locked   = 0;
            m_in_frame = 0;
            m_run      = 0;
            m_q.delete();
            m_ovf      = 0;
            m_ferr     = 0;
            m_sync     = 0;
        end else begin
            if (!m_locked) begin
                if (w == 28'd1) begin
                    m_run++;
                    if (m_run == STABLE) begin
                        m_locked = 1;
                        m_sync   = 1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (!m_in_frame) begin
                if (w == START) begin
                    m_in_frame = 1;
                    m_k        = 0;
                end else if (w != 28'd0 && w != 28'd1) begin
                    m_ferr = 1;
                end
            end else begin
                m_pay[m_k*28 +: 28] = w;
                m_k++;
                if (m_k == FOLDS) begin
                    push       = 1;
                    np         = m_pay;
                    m_in_frame = 0;
                end
            end
            pull_ok = pl && (m_q.size() > 0);
            if (push && m_q.size() == 2 && !pull_ok) begin
                m_ovf = 1;
            end else begin
                if (pull_ok) void'(m_q.pop_front());
                if (push) m_q.push_back(np);
            end
        end
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic chk_model();
        chk("avail", {63'd0, o_rx_available}, {63'd0, (m_q.size() > 0)});
        chk("sync",  {63'd0, o_sync_complete}, {63'd0, m_sync});
        chk("ovf",   {63'd0, o_overflow}, {63'd0, m_ovf});
        chk("ferr",  {63'd0, o_frame_err}, {63'd0, m_ferr});
        chk("dt",    o_dt, m_head[63:0]);
        chk("vl",    {56'd0, o_vl}, {56'd0, m_head[71:64]});
        chk("cr",    {56'd0, o_cr}, {56'd0, m_head[79:72]});
    endtask

    task automatic step(input logic [27:0] w, input logic sg, input logic pl);
        i_word          = w;
        i_sync_generate = sg;
        i_rx_pull       = pl;
        model_update(w, sg, pl);
        @(posedge i_clk);
        #1;
        chk_model();
    endtask

    task automatic send_frame(input logic [27:0] w2, input logic pull_last);
        step(START, 0, 0);
        step(28'($urandom()), 0, 0);
        step(28'($urandom()), 0, 0);
        step(w2, 0, pull_last);
    endtask

    task automatic relock();
        for (int i = 0; i < STABLE; i++) step(28'd1, 0, 0);
    endtask

    task automatic add(input logic [27:0] w, input logic es, input logic ea, input logic eo,
                       input logic ef);
        tbl[n_tbl].word    = w;
        tbl[n_tbl].sg      = 0;
        tbl[n_tbl].pull    = 0;
        tbl[n_tbl].e_sync  = es;
        tbl[n_tbl].e_avail = ea;
        tbl[n_tbl].e_ovf   = eo;
        tbl[n_tbl].e_ferr  = ef;
        n_tbl++;
    endtask

    localparam logic [27:0] FA = 28'h011A101;
    localparam logic [27:0] FB = 28'h022B202;
    localparam logic [27:0] FC = 28'h033C303;
    localparam logic [27:0] FD = 28'h044D404;

    initial begin
        logic [27:0] w0, w1, w2;
        logic [63:0] exp_dt;
        w0 = 28'hABCDEF1;
        w1 = 28'h2468ACE;
        w2 = 28'h0C3A5F1;
        exp_dt = {w2[7:0], w1, w0};

        for (int i = 0; i < 7; i++) add(28'd1, 0, 0, 0, 0);
        add(28'd0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(28'd1, 0, 0, 0, 0);
        add(28'd1, 1, 0, 0, 0);
        add(START, 1, 0, 0, 0);
        add(w0, 1, 0, 0, 0);
        add(w1, 1, 0, 0, 0);
        add(w2, 1, 1, 0, 0);
        add(28'h1234567, 1, 1, 0, 1);
        add(28'd0, 1, 1, 0, 1);

        i_rst = 1'b1;
        i_word = '0;
        i_sync_generate = 1'b0;
        i_rx_pull = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_avail", {63'd0, o_rx_available}, 64'd0);
        chk("rst_sync",  {63'd0, o_sync_complete}, 64'd0);
        chk("rst_ovf",   {63'd0, o_overflow}, 64'd0);
        chk("rst_ferr",  {63'd0, o_frame_err}, 64'd0);
        chk("rst_dt",    o_dt, 64'd0);
        chk("rst_vl",    {56'd0, o_vl}, 64'd0);
        chk("rst_cr",    {56'd0, o_cr}, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Sync lock, first frame decode, frame error.
        for (int i = 0; i < n_tbl; i++) begin
            step(tbl[i].word, tbl[i].sg, tbl[i].pull);
            chk($sformatf("tbl%0d_sync", i),  {63'd0, o_sync_complete}, {63'd0, tbl[i].e_sync});
            chk($sformatf("tbl%0d_avail", i), {63'd0, o_rx_available}, {63'd0, tbl[i].e_avail});
            chk($sformatf("tbl%0d_ovf", i),   {63'd0, o_overflow}, {63'd0, tbl[i].e_ovf});
            chk($sformatf("tbl%0d_ferr", i),  {63'd0, o_frame_err}, {63'd0, tbl[i].e_ferr});
        end
        chk("frame_dt7", {56'd0, o_dt[7]}, 64'hF1);
        chk("frame_vl",  {56'd0, o_vl}, 64'hA5);
        chk("frame_cr",  {56'd0, o_cr}, 64'hC3);
        chk("frame_dt",  o_dt, exp_dt);

        // Frame after an error decodes; push+pull with one entry replaces the head.
        send_frame(FD, 1);
        chk("d_avail", {63'd0, o_rx_available}, 64'd1);
        chk("d_vl", {56'd0, o_vl}, 64'hD4);
        chk("d_cr", {56'd0, o_cr}, 64'h44);
        step(28'd0, 0, 1);
        chk("d_empty", {63'd0, o_rx_available}, 64'd0);
        chk("d_hold_vl", {56'd0, o_vl}, 64'hD4);
        step(28'd0, 0, 1);
        chk("pull_empty_ignored", {63'd0, o_rx_available}, 64'd0);

        // Overflow on a third frame with no pull.
        send_frame(FA, 0);
        send_frame(FB, 0);
        send_frame(FC, 0);
        chk("ovf_set", {63'd0, o_overflow}, 64'd1);
        chk("ovf_headA", {56'd0, o_vl}, 64'hA1);
        step(28'd0, 0, 1);
        chk("ovf_headB", {56'd0, o_vl}, 64'hB2);
        step(28'd0, 0, 1);
        chk("ovf_empty", {63'd0, o_rx_available}, 64'd0);

        // Full queue with push and pull together.
        step(28'd1, 1, 0);
        chk("sg_clr_ovf", {63'd0, o_overflow}, 64'd0);
        relock();
        chk("relock", {63'd0, o_sync_complete}, 64'd1);
        send_frame(FA, 0);
        send_frame(FB, 0);
        send_frame(FC, 1);
        chk("full_pp_ovf", {63'd0, o_overflow}, 64'd0);
        chk("full_pp_headB", {56'd0, o_vl}, 64'hB2);
        step(28'd0, 0, 1);
        chk("full_pp_headC", {56'd0, o_vl}, 64'hC3);
        chk("full_pp_avail", {63'd0, o_rx_available}, 64'd1);
        step(28'd0, 0, 1);
        chk("full_pp_empty", {63'd0, o_rx_available}, 64'd0);

        // Resync mid-frame clears everything; lock needs a fresh run after deassertion.
        send_frame(FA, 0);
        send_frame(FB, 0);
        send_frame(FC, 0);
        step(28'h1234567, 0, 0);
        chk("pre_rs_ovf", {63'd0, o_overflow}, 64'd1);
        chk("pre_rs_ferr", {63'd0, o_frame_err}, 64'd1);
        step(START, 0, 0);
        step(28'h1111111, 0, 0);
        step(28'h2222222, 0, 0);
        step(28'd1, 1, 0);
        chk("rs_sync", {63'd0, o_sync_complete}, 64'd0);
        chk("rs_avail", {63'd0, o_rx_available}, 64'd0);
        chk("rs_ovf", {63'd0, o_overflow}, 64'd0);
        chk("rs_ferr", {63'd0, o_frame_err}, 64'd0);
        step(28'd1, 1, 0);
        step(28'd1, 1, 0);
        for (int i = 0; i < STABLE - 1; i++) step(28'd1, 0, 0);
        chk("rs_not_locked", {63'd0, o_sync_complete}, 64'd0);
        step(28'd1, 0, 0);
        chk("rs_locked", {63'd0, o_sync_complete}, 64'd1);

        // Asynchronous reset mid-frame.
        send_frame(FB, 0);
        step(START, 0, 0);
        step(28'h3333333, 0, 0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_sync", {63'd0, o_sync_complete}, 64'd0);
        chk("arst_avail", {63'd0, o_rx_available}, 64'd0);
        chk("arst_vl", {56'd0, o_vl}, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        relock();
        send_frame(FC, 0);
        chk("arst_frame_vl", {56'd0, o_vl}, 64'hC3);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [27:0] w;
            logic        sg;
            logic        pl;
            int          r;
            r  = int'($urandom_range(0, 99));
            sg = ($urandom_range(0, 199) == 0);
            pl = ($urandom_range(0, 99) < 30);
            if (!m_locked) begin
                w = (r < 92) ? 28'd1 : 28'($urandom_range(0, 3));
            end else if (!m_in_frame) begin
                if (r < 45)      w = START;
                else if (r < 70) w = 28'd0;
                else if (r < 95) w = 28'd1;
                else             w = 28'($urandom());
            end else begin
                w = 28'($urandom());
            end
            step(w, sg, pl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
